// File: rtl/code_table_ctrl_if.sv
// Builder/decoder side bus of the code-table controller.
// The master modport is the requester side; the controller takes the slave modport.
interface code_table_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          wr_en;
    logic [7:0]    wr_char;
    logic [3:0]    wr_length;
    logic [11:0]   wr_path;
    logic          save_comp;
    logic          table_clear;
    logic          srch_req;
    logic [11:0]   srch_bits;
    logic [3:0]    srch_len;
    logic          srch_ack;
    logic          srch_hit;
    logic [7:0]    srch_char;
    logic [CW-1:0] entry_count;
    logic          overflow;

    modport master (
        output wr_en, wr_char, wr_length, wr_path, table_clear,
        output srch_req, srch_bits, srch_len,
        input  save_comp, srch_ack, srch_hit, srch_char, entry_count, overflow
    );

    modport slave (
        input  wr_en, wr_char, wr_length, wr_path, table_clear,
        input  srch_req, srch_bits, srch_len,
        output save_comp, srch_ack, srch_hit, srch_char, entry_count, overflow
    );
endinterface

// File: rtl/code_table_ctrl.sv
// Shared code table: the builder appends {char, length, path} entries and the decoder
// scans them one entry per cycle for a length-qualified match on the accumulated bits.
module code_table_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    code_table_ctrl_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] W_ACK  = 3'd2;
    localparam logic [2:0] SEARCH = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    logic [2:0]    state;
    logic [7:0]    tbl_char [DEPTH];
    logic [3:0]    tbl_len  [DEPTH];
    logic [11:0]   tbl_path [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] scan_idx;
    logic          overflow_q;
    logic          hit_q;
    logic [7:0]    char_q;
    logic [3:0]    key_len;
    logic [11:0]   key_bits;

    logic [IW-1:0] scan_addr;
    logic [IW-1:0] wr_addr;
    logic [11:0]   len_mask;
    logic          full;
    logic          entry_match;

    assign scan_addr = scan_idx[IW-1:0];
    assign wr_addr   = count[IW-1:0];
    assign full      = (count == CW'(DEPTH));

    // Only the low key_len bits take part in the compare; lengths of 12+ use all bits.
    assign len_mask    = ~(12'hFFF << key_len);
    assign entry_match = (key_len != 4'd0) &&
                         (tbl_len[scan_addr] == key_len) &&
                         (((tbl_path[scan_addr] ^ key_bits) & len_mask) == 12'd0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            count      <= '0;
            scan_idx   <= '0;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
            char_q     <= 8'd0;
            key_len    <= 4'd0;
            key_bits   <= 12'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_char[i] <= 8'd0;
                tbl_len[i]  <= 4'd0;
                tbl_path[i] <= 12'd0;
            end
        end else if (bus.table_clear) begin
            state      <= IDLE;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        state <= WRITE;
                    end else if (bus.srch_req) begin
                        state    <= SEARCH;
                        scan_idx <= '0;
                        hit_q    <= 1'b0;
                        char_q   <= 8'd0;
                        key_len  <= bus.srch_len;
                        key_bits <= bus.srch_bits;
                    end
                end
                WRITE: begin
                    // A full table drops the entry but still acknowledges the builder.
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        tbl_char[wr_addr] <= bus.wr_char;
                        tbl_len[wr_addr]  <= bus.wr_length;
                        tbl_path[wr_addr] <= bus.wr_path;
                        count             <= count + CW'(1);
                    end
                    state <= W_ACK;
                end
                W_ACK: begin
                    state <= IDLE;
                end
                SEARCH: begin
                    if (scan_idx == count) begin
                        state <= RESULT;
                    end else if (entry_match) begin
                        hit_q  <= 1'b1;
                        char_q <= tbl_char[scan_addr];
                        state  <= RESULT;
                    end else begin
                        scan_idx <= scan_idx + CW'(1);
                    end
                end
                RESULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pulses are suppressed in the cycle a clear or reset aborts the transaction.
    assign bus.save_comp   = (state == W_ACK)  && n_rst && !bus.table_clear;
    assign bus.srch_ack    = (state == RESULT) && n_rst && !bus.table_clear;
    assign bus.srch_hit    = hit_q;
    assign bus.srch_char   = char_q;
    assign bus.entry_count = count;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_code_table_ctrl.sv
// Directed bench for code_table_ctrl: stores, hit/miss searches, overflow, clear and
// reset aborts, with latencies counted in clock edges from the request being raised.
module tb_code_table_ctrl;
    logic clk = 1'b0;
    logic n_rst;
    int   vectors     = 0;
    int   miscompares = 0;

    code_table_ctrl_if bus ();

    code_table_ctrl #(.DEPTH(16)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic sr, input logic clr);
        bus.wr_en       = we;
        bus.srch_req    = sr;
        bus.table_clear = clr;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseClear();
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Raise wr_en, count edges until save_comp is seen, then confirm it is one cycle wide.
    task automatic writeEntry(input string tag, input logic [7:0] c, input logic [3:0] l,
                              input logic [11:0] p, input int exp_lat);
        int n = 0;
        bus.wr_char   = c;
        bus.wr_length = l;
        bus.wr_path   = p;
        bus.wr_en     = 1'b1;
        while (n < 40 && !bus.save_comp) begin
            stepCycle();
            n++;
        end
        bus.wr_en = 1'b0;
        checkOutput({tag, "_lat"}, 32'(n), 32'(exp_lat));
        stepCycle();
        checkOutput({tag, "_pulse"}, {31'd0, bus.save_comp}, 32'd0);
    endtask

    task automatic searchKey(input string tag, input logic [3:0] l, input logic [11:0] b,
                             input int exp_lat, input logic exp_hit, input logic [7:0] exp_char);
        int n = 0;
        bus.srch_len  = l;
        bus.srch_bits = b;
        bus.srch_req  = 1'b1;
        while (n < 40 && !bus.srch_ack) begin
            stepCycle();
            n++;
        end
        bus.srch_req = 1'b0;
        checkOutput({tag, "_lat"}, 32'(n), 32'(exp_lat));
        checkOutput({tag, "_hit"}, {31'd0, bus.srch_hit}, {31'd0, exp_hit});
        checkOutput({tag, "_char"}, {24'd0, bus.srch_char}, {24'd0, exp_char});
        stepCycle();
        checkOutput({tag, "_ack_drop"}, {31'd0, bus.srch_ack}, 32'd0);
        checkOutput({tag, "_hit_hold"}, {31'd0, bus.srch_hit}, {31'd0, exp_hit});
    endtask

    initial begin
        int n;
        int ack_seen;

        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.wr_char   = 8'd0;
        bus.wr_length = 4'd0;
        bus.wr_path   = 12'd0;
        bus.srch_len  = 4'd0;
        bus.srch_bits = 12'd0;
        n_rst         = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        checkOutput("rst_count", 32'(bus.entry_count), 32'd0);
        checkOutput("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        checkOutput("rst_save", {31'd0, bus.save_comp}, 32'd0);
        checkOutput("rst_ack", {31'd0, bus.srch_ack}, 32'd0);
        checkOutput("rst_hit", {31'd0, bus.srch_hit}, 32'd0);
        checkOutput("rst_char", {24'd0, bus.srch_char}, 32'd0);

        $display("[TB] two-entry table");
        writeEntry("wr_A", 8'h41, 4'd3, 12'b101, 2);
        checkOutput("count_1", 32'(bus.entry_count), 32'd1);
        writeEntry("wr_B", 8'h42, 4'd2, 12'b01, 2);
        checkOutput("count_2", 32'(bus.entry_count), 32'd2);
        searchKey("s_B", 4'd2, 12'h001, 3, 1'b1, 8'h42);
        searchKey("s_A", 4'd3, 12'hFFD, 2, 1'b1, 8'h41);
        searchKey("s_miss", 4'd4, 12'h005, 4, 1'b0, 8'h00);
        searchKey("s_len0", 4'd0, 12'h000, 4, 1'b0, 8'h00);

        pulseClear();
        checkOutput("clr_count", 32'(bus.entry_count), 32'd0);
        searchKey("s_empty", 4'd3, 12'h005, 2, 1'b0, 8'h00);

        $display("[TB] full table and overflow");
        for (int i = 0; i < 16; i++) begin
            writeEntry("fill", 8'(8'h61 + i), 4'd4, 12'(i), 2);
        end
        checkOutput("full_count", 32'(bus.entry_count), 32'd16);
        checkOutput("full_ovf", {31'd0, bus.overflow}, 32'd0);
        writeEntry("wr_ovf", 8'h58, 4'd4, 12'h000, 2);
        checkOutput("ovf_count", 32'(bus.entry_count), 32'd16);
        checkOutput("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        searchKey("s_first", 4'd4, 12'h000, 2, 1'b1, 8'h61);
        searchKey("s_upper", 4'd4, 12'h1F5, 7, 1'b1, 8'h66);
        searchKey("s_last", 4'd4, 12'h00F, 17, 1'b1, 8'h70);
        searchKey("s_fullmiss", 4'd5, 12'h000, 18, 1'b0, 8'h00);
        pulseClear();
        checkOutput("clr2_count", 32'(bus.entry_count), 32'd0);
        checkOutput("clr2_ovf", {31'd0, bus.overflow}, 32'd0);

        $display("[TB] simultaneous write and search");
        bus.wr_char   = 8'h5A;
        bus.wr_length = 4'd4;
        bus.wr_path   = 12'h00A;
        bus.srch_len  = 4'd4;
        bus.srch_bits = 12'h00A;
        applyStimulus(1'b1, 1'b1, 1'b0);
        n = 0;
        while (n < 40 && !bus.save_comp && !bus.srch_ack) begin
            stepCycle();
            n++;
        end
        bus.wr_en = 1'b0;
        checkOutput("both_save_lat", 32'(n), 32'd2);
        checkOutput("both_save_first", {31'd0, bus.srch_ack}, 32'd0);
        while (n < 40 && !bus.srch_ack) begin
            stepCycle();
            n++;
        end
        bus.srch_req = 1'b0;
        checkOutput("both_ack_lat", 32'(n), 32'd5);
        checkOutput("both_hit", {31'd0, bus.srch_hit}, 32'd1);
        checkOutput("both_char", {24'd0, bus.srch_char}, 32'h5A);
        stepCycle();

        $display("[TB] clear during search");
        writeEntry("wr_c1", 8'h31, 4'd4, 12'h001, 2);
        writeEntry("wr_c2", 8'h32, 4'd4, 12'h002, 2);
        bus.srch_len  = 4'd3;
        bus.srch_bits = 12'h007;
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        ack_seen = (bus.srch_ack) ? 1 : 0;
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_count", 32'(bus.entry_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (bus.srch_ack) ack_seen++;
            stepCycle();
        end
        checkOutput("abort_no_ack", 32'(ack_seen), 32'd0);

        $display("[TB] reset during write");
        bus.wr_char   = 8'h51;
        bus.wr_length = 4'd2;
        bus.wr_path   = 12'h003;
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        n_rst = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        checkOutput("rstw_no_save", {31'd0, bus.save_comp}, 32'd0);
        stepCycle();
        n_rst = 1'b1;
        checkOutput("rstw_count", 32'(bus.entry_count), 32'd0);
        checkOutput("rstw_save", {31'd0, bus.save_comp}, 32'd0);
        searchKey("s_after_rst", 4'd2, 12'h003, 2, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
